// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/addr_ok/data_ok fetch handshake
// against the instruction SRAM and presents {ce, pc} plus the fetched word to ID.
`timescale 1ns/1ps
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
  parameter int          IF_TO_ID_WD = 33,
  parameter int          BR_WD       = 33,
  parameter int          STALL_WD    = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [31:0]            inst_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            if_inst,
  output logic                   stallreq,
  output logic [1:0]             dbg_state
);

  // SRAM handshake: a request is accepted in any cycle with inst_req & inst_addr_ok;
  // inst_addr holds pc_q until then. Read data returns later with inst_data_ok, in order,
  // at most one fetch outstanding. The ID side sees a valid word only when ce=1.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ibuf_q, ibuf_d;

  logic        br_e;
  logic [31:0] br_addr;
  logic        ce;
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign unused_stall = ^stall[STALL_WD-1:1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ibuf_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ibuf_d  = ibuf_q;
    unique case (state_q)
      S_REQ: begin
        if (flush) begin
          pc_d    = flush_pc;
          // An accepted request still owes us a data beat, which must be thrown away.
          state_d = inst_addr_ok ? S_DROP : S_REQ;
        end else if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = inst_data_ok ? S_REQ : S_DROP;
        end else if (inst_data_ok) begin
          ibuf_d  = inst_rdata;
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (flush) pc_d = flush_pc;
        if (inst_data_ok) state_d = S_REQ;
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = S_REQ;
        end else if (!stall[0]) begin
          pc_d    = br_e ? br_addr : pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign ce           = (state_q == S_HOLD);
  assign inst_req     = (state_q == S_REQ);
  assign inst_addr    = pc_q;
  assign if_to_id_bus = ce ? {1'b1, pc_q} : '0;
  assign if_inst      = ce ? ibuf_q : 32'b0;
  assign stallreq     = ~ce;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a cycle table of SRAM/pipeline inputs with the expected
// Moore outputs, followed by a hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_if_fetch;

  localparam logic [1:0] R = 2'd0, W = 2'd1, D = 2'd2, H = 2'd3;

  logic        clk;
  logic        resetn;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        stallreq;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        st;
    logic        be;
    logic [31:0] ba;
    logic        ao;
    logic        dok;
    logic [31:0] rd;
    logic [1:0]  es;
    logic [31:0] ea;
    logic [31:0] ei;
  } vec_t;

  vec_t vecs[$];

  if_fetch dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (stall),
    .br_bus       (br_bus),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_to_id_bus (if_to_id_bus),
    .if_inst      (if_inst),
    .stallreq     (stallreq),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic fl, logic [31:0] fpc, logic st, logic be, logic [31:0] ba,
                             logic ao, logic dok, logic [31:0] rd,
                             logic [1:0] es, logic [31:0] ea, logic [31:0] ei);
    vec_t r;
    r.fl = fl; r.fpc = fpc; r.st = st; r.be = be; r.ba = ba;
    r.ao = ao; r.dok = dok; r.rd = rd;
    r.es = es; r.ea = ea; r.ei = ei;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush        = 1'b0;
    flush_pc     = 32'h0;
    stall        = 6'b000001;
    br_bus       = 33'h0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  task automatic drive_vec(input vec_t x);
    flush        = x.fl;
    flush_pc     = x.fpc;
    stall        = {5'($urandom_range(0, 31)), x.st};
    br_bus       = {x.be, x.ba};
    inst_addr_ok = x.ao;
    inst_data_ok = x.dok;
    inst_rdata   = x.rd;
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] es, input logic [31:0] ea,
                               input logic [31:0] ei);
    logic        ce;
    logic [32:0] bus;
    ce  = (es == H);
    bus = ce ? {1'b1, ea} : 33'h0;
    chk({tag, " state"},    64'(dbg_state),    64'(es));
    chk({tag, " inst_req"}, 64'(inst_req),     64'(es == R));
    chk({tag, " inst_addr"},64'(inst_addr),    64'(ea));
    chk({tag, " bus"},      64'(if_to_id_bus), 64'(bus));
    chk({tag, " if_inst"},  64'(if_inst),      64'(ce ? ei : 32'h0));
    chk({tag, " stallreq"}, 64'(stallreq),     64'(!ce));
  endtask

  initial begin
    drive_idle();
    resetn = 1'b0;
    #12;
    check_outputs("reset", R, 32'hbfc0_0000, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    //              fl fpc            st be ba            ao dok rd             es ea             ei
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'hbfc0_0000, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h3c01_bfaf, W, 32'hbfc0_0000, 32'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         H, 32'hbfc0_0000, 32'h3c01_bfaf));
    vecs.push_back(v(0, 32'h0,          0, 1, 32'hbfc0_0100, 0, 0, 32'h0,         H, 32'hbfc0_0000, 32'h3c01_bfaf));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 32'h0,        0, 0, 32'h0,         0, 0, 32'h0,         R, 32'hbfc0_0100, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'hbfc0_0100, 32'h0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 32'h0,        0, 0, 32'h0,         0, 0, 32'h0,         W, 32'hbfc0_0100, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h2408_0001, W, 32'hbfc0_0100, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0,         H, 32'hbfc0_0100, 32'h2408_0001));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'hbfc0_0104, 32'h0));
    vecs.push_back(v(1, 32'hbfc0_0380,  0, 0, 32'h0,         0, 0, 32'h0,         W, 32'hbfc0_0104, 32'h0));
    vecs.push_back(v(1, 32'hbfc0_0390,  0, 0, 32'h0,         0, 0, 32'h0,         D, 32'hbfc0_0380, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'hdead_beef, D, 32'hbfc0_0390, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'hbfc0_0390, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h4080_6000, W, 32'hbfc0_0390, 32'h0));
    vecs.push_back(v(1, 32'h8000_0180,  0, 1, 32'hbfc0_0500, 0, 0, 32'h0,         H, 32'hbfc0_0390, 32'h4080_6000));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0,         R, 32'h8000_0180, 32'h0));
    vecs.push_back(v(1, 32'hffff_fffc,  0, 0, 32'h0,         1, 0, 32'h0,         R, 32'h8000_0180, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h1111_1111, D, 32'hffff_fffc, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'hffff_fffc, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h8fa2_0010, W, 32'hffff_fffc, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0,         H, 32'hffff_fffc, 32'h8fa2_0010));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'h0000_0000, 32'h0));
    vecs.push_back(v(1, 32'hbfc0_0200,  0, 0, 32'h0,         0, 1, 32'hcafe_f00d, W, 32'h0000_0000, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h1234_5678, R, 32'hbfc0_0200, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'hbfc0_0200, 32'h0));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h0000_000c, W, 32'hbfc0_0200, 32'h0));
    vecs.push_back(v(0, 32'h0,          1, 0, 32'h0,         0, 1, 32'h9999_9999, H, 32'hbfc0_0200, 32'h0000_000c));
    vecs.push_back(v(0, 32'h0,          1, 0, 32'h0,         0, 0, 32'h0,         H, 32'hbfc0_0200, 32'h0000_000c));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0,         H, 32'hbfc0_0200, 32'h0000_000c));
    vecs.push_back(v(0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         R, 32'hbfc0_0204, 32'h0));

    // Each vector is driven after the falling edge and its outputs (registered state
    // only) are checked before the next rising edge.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].es, vecs[i].ea, vecs[i].ei);
    end

    // Reset asserted between clock edges while a fetch is outstanding.
    @(negedge clk);
    drive_idle();
    #1;
    check_outputs("pre_reset", W, 32'hbfc0_0204, 32'h0);
    #1;
    resetn = 1'b0;
    #1;
    check_outputs("async_reset", R, 32'hbfc0_0000, 32'h0);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h5555_aaaa;
    @(negedge clk);
    #1;
    check_outputs("reset_held", R, 32'hbfc0_0000, 32'h0);
    resetn       = 1'b1;
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    #1;
    check_outputs("restart_req", R, 32'hbfc0_0000, 32'h0);
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h0000_0001;
    #1;
    check_outputs("restart_wait", W, 32'hbfc0_0000, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    check_outputs("restart_hold", H, 32'hbfc0_0000, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
